decode_hazard_ctrl: RTL
=======================

Name: decode_hazard_ctrl

Overview:
- Sequences operand delivery for the decode stage of the 5-stage pipeline.
- Tracks destination register and result class of the instructions in E, M and W in an internal shadow pipeline.
- Drives the decode forwarding selects (select_out1/select_out2) and the stall/bubble controls.
- All forwarding happens at the D-stage read muxes; an operand must be valid before its instruction leaves D.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- Instr_D  input  32  instruction currently in D
- select_out1  output  5  rs source select: 0 GRF, 1 jal_pc_from_E, 2 ALUResult (M), 3 jal_pc_from_M, 4 WriteData (W)
- select_out2  output  5  rt source select, same encoding
- stall  output  1  hold PC and IF/D register
- bubble_E  output  1  load NOP into D/E register
- Reg_write  output  5  W-stage destination register, 0 if none
- GRF_en  output  1  W-stage register-file write enable
- stall_cnt  output  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Decode of Instr_D (combinational) gives: uses_rs, uses_rt, dst, cls.
  - cls values: NONE, ALU, LOAD, LINK.
  - ALU R-type (addu/add/subu/sub/and/or/xor/nor/slt/sltu/sllv/srlv/srav/sll/srl/sra): dst=rd, cls=ALU. Shifts by shamt have uses_rs=0.
  - I-type ALU (ori/xori/andi/slti/sltiu/addi/addiu/lui): dst=rt, cls=ALU, uses_rt=0. lui has uses_rs=0.
  - lw/lb/lbu/lh/lhu: dst=rt, cls=LOAD.
  - sw/sb/sh: uses rs and rt, cls=NONE.
  - beq/bne: use rs and rt. bgez/bltz/bgtz/blez: use rs only. jr: uses rs. All cls=NONE.
  - jal: dst=31, cls=LINK. jalr: dst=rd, cls=LINK, uses rs.
  - j, nop (Instr_D==0), unknown opcodes: cls=NONE, no uses.
  - dst==0 forces cls=NONE.
- Shadow pipeline: three registers E, M, W, each holding {dst[4:0], cls[1:0]}, updated on posedge clk.
  - Normal cycle: E<=decode(Instr_D), M<=E, W<=M.
  - Stall cycle: E<=NONE (bubble), M<=E, W<=M.
- Hazard on a used operand r≠0 (checked against E first, then M):
  - stall if E.dst==r and E.cls in {ALU, LOAD};
  - stall if M.dst==r and M.cls==LOAD.
  - stall = hazard on rs OR hazard on rt. bubble_E = stall.
- Forward select for operand r with no stall; first match wins, priority E > M > W:
  - E.dst==r and E.cls==LINK -> 1
  - M.dst==r and M.cls==ALU -> 2
  - M.dst==r and M.cls==LINK -> 3
  - W.dst==r and W.cls≠NONE -> 4
  - otherwise 0.
  - Unused operand or r==0 -> select 0.
  - Selects are combinational from the shadow regs and Instr_D: zero-latency, valid during stall cycles.
- Reg_write = W.dst. GRF_en = (W.cls≠NONE).
- stall_cnt: increments on every clk edge where stall==1, holds at all-ones.
- Reset (async, any time including mid-stall): E, M, W cleared to NONE/0 and stall_cnt=0.
  - Consequently select_out1=select_out2=0, stall=0, bubble_E=0, Reg_write=0, GRF_en=0 while reset is high and on the first cycle after release.
- Worst case is a load followed immediately by a consumer: exactly 2 stall cycles.
- A LINK producer never stalls.
- A producer to $0 never stalls or forwards.

Test Plan:
- addu $3,$1,$2 then beq $3,$4: cycle 1 stall=1, bubble_E=1; cycle 2 stall=0, select_out1=2, select_out2=0; stall_cnt=1.
- lw $5,0($0) then addu $6,$5,$5: stall for 2 cycles. Third cycle select_out1=select_out2=4. Reg_write=5 and GRF_en=1 in that cycle.
- jal then jr $31 next: no stall, select_out1=1. Inserting one nop between them gives select_out1=3; two nops give 4.
- ori $0,$1,5 then addu $2,$0,$0: no stall, selects 0, GRF_en=0 when it reaches W.
- addu $3 in M and lw $3 in E while D uses $3: E has priority, so stall=1. Never select 2.
- Assert reset mid-stall (lw then dependent addu): outputs return to 0 immediately (async). After release, the dependent instruction issues with select 0; stall_cnt restarts from 0.

Source files
------------

// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: decode-stage operand forwarding selects, load/ALU stall control
// and a shadow E/M/W pipeline of destination register and result class.
module decode_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      Instr_D,
   output logic [4:0]       select_out1,
   output logic [4:0]       select_out2,
   output logic             stall,
   output logic             bubble_E,
   output logic [4:0]       Reg_write,
   output logic             GRF_en,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic [1:0] {C_NONE, C_ALU, C_LOAD, C_LINK} cls_t;
   typedef struct packed {
      logic [4:0] dst;
      cls_t       cls;
   } ent_t;

   logic [5:0] op, fn;
   logic [4:0] rs, rt, rd;
   logic       uses_rs, uses_rt;
   ent_t       dec, e_q, m_q, w_q;
   logic [5:0] fwd1, fwd2;

   assign op = Instr_D[31:26];
   assign rs = Instr_D[25:21];
   assign rt = Instr_D[20:16];
   assign rd = Instr_D[15:11];
   assign fn = Instr_D[5:0];

   always_comb begin
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      dec     = '{5'd0, C_NONE};
      if (Instr_D != '0) begin
         case (op)
            6'h00:
               case (fn)
                  6'h00, 6'h02, 6'h03: begin
                     uses_rt = 1'b1;
                     dec     = '{rd, C_ALU};
                  end
                  6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                  6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
                     uses_rs = 1'b1;
                     uses_rt = 1'b1;
                     dec     = '{rd, C_ALU};
                  end
                  6'h08: uses_rs = 1'b1;
                  6'h09: begin
                     uses_rs = 1'b1;
                     dec     = '{rd, C_LINK};
                  end
                  default: ;
               endcase
            6'h01: uses_rs = (rt[4:1] == 4'd0);
            6'h03: dec = '{5'd31, C_LINK};
            6'h04, 6'h05, 6'h28, 6'h29, 6'h2b: begin
               uses_rs = 1'b1;
               uses_rt = 1'b1;
            end
            6'h06, 6'h07: uses_rs = 1'b1;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin
               uses_rs = 1'b1;
               dec     = '{rt, C_ALU};
            end
            6'h0f: dec = '{rt, C_ALU};
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
               uses_rs = 1'b1;
               dec     = '{rt, C_LOAD};
            end
            default: ;
         endcase
      end
      if (dec.dst == 5'd0) dec.cls = C_NONE;
   end

   // {stall, select}: the youngest stage writing r decides; older writers are stale
   function automatic logic [5:0] resolve(input logic [4:0] r, input logic used,
                                          input ent_t e, input ent_t m, input ent_t w);
      if (!used || r == 5'd0) return 6'd0;
      if (e.cls != C_NONE && e.dst == r) return (e.cls == C_LINK) ? 6'd1 : 6'h20;
      if (m.cls != C_NONE && m.dst == r)
         return (m.cls == C_LOAD) ? 6'h20 : (m.cls == C_ALU) ? 6'd2 : 6'd3;
      if (w.cls != C_NONE && w.dst == r) return 6'd4;
      return 6'd0;
   endfunction

   assign fwd1        = resolve(rs, uses_rs, e_q, m_q, w_q);
   assign fwd2        = resolve(rt, uses_rt, e_q, m_q, w_q);
   assign stall       = fwd1[5] | fwd2[5];
   assign bubble_E    = stall;
   assign select_out1 = fwd1[4:0];
   assign select_out2 = fwd2[4:0];
   assign Reg_write   = w_q.dst;
   assign GRF_en      = w_q.cls != C_NONE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q       <= '0;
         m_q       <= '0;
         w_q       <= '0;
         stall_cnt <= '0;
      end else begin
         e_q <= stall ? '0 : dec;
         m_q <= e_q;
         w_q <= m_q;
         if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
endmodule
